// File: rtl/square_op_scheduler.sv
// Queues erase/draw requests for grid squares and runs them one at a time through the
// shared square-fill engine, gating the engine's pixel stream onto the VGA write port.
module square_op_scheduler #(
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 6,
  parameter int TIMEOUT = 4095
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [3:0] req_gx,
  input  logic [3:0] req_gy,
  output logic       eng_start,
  output logic       eng_op,
  output logic [3:0] eng_gx,
  output logic [3:0] eng_gy,
  input  logic       eng_done,
  input  logic       eng_pix_valid,
  input  logic [7:0] eng_x,
  input  logic [6:0] eng_y,
  input  logic [8:0] eng_colour,
  output logic       vga_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [8:0] vga_colour,
  output logic       busy,
  output logic [2:0] fifo_count,
  output logic       err_range,
  output logic       err_timeout
);

  localparam int              WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [3:0]      GW       = 4'(GRID_W);
  localparam logic [3:0]      GH       = 4'(GRID_H);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, GAP} state_t;

  state_t          state_q, state_d;
  logic [8:0]      fifo_q [4];
  logic [1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]      count_q, count_d;
  logic [WD_W-1:0] wd_q, wd_d, wd_inc;
  logic            eng_op_q, eng_op_d;
  logic [3:0]      eng_gx_q, eng_gx_d, eng_gy_q, eng_gy_d;
  logic            err_range_q, err_range_d, err_timeout_q, err_timeout_d;
  logic            push, pop, head_legal, timeout_hit;
  logic [8:0]      head;

  assign push        = req_valid && req_ready;
  assign pop         = (state_q == IDLE) && (count_q != 3'd0);
  assign head        = fifo_q[rd_ptr_q];
  assign head_legal  = (head[7:4] < GW) && (head[3:0] < GH);
  assign wd_inc      = wd_q + WD_W'(1);
  assign timeout_hit = (state_q == RUN) && !eng_done && (wd_inc == WD_LIMIT);

  // FIFO bookkeeping; entry storage itself is never reset
  always_comb begin
    rd_ptr_d = rd_ptr_q + 2'(pop);
    wr_ptr_d = wr_ptr_q + 2'(push);
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {req_op, req_gx, req_gy};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      wd_q          <= '0;
      eng_op_q      <= 1'b0;
      eng_gx_q      <= '0;
      eng_gy_q      <= '0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      wd_q          <= wd_d;
      eng_op_q      <= eng_op_d;
      eng_gx_q      <= eng_gx_d;
      eng_gy_q      <= eng_gy_d;
      err_range_q   <= err_range_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop && head_legal) state_d = LAUNCH;
      LAUNCH:  state_d = RUN;
      RUN:     if (eng_done || timeout_hit) state_d = GAP;
      default: state_d = IDLE;
    endcase
  end

  // Job registers load only on a legal pop; illegal heads are dropped and flagged
  always_comb begin
    eng_op_d      = eng_op_q;
    eng_gx_d      = eng_gx_q;
    eng_gy_d      = eng_gy_q;
    err_range_d   = err_range_q;
    err_timeout_d = err_timeout_q || timeout_hit;
    wd_d          = wd_q;
    if (pop && head_legal) begin
      eng_op_d = head[8];
      eng_gx_d = head[7:4];
      eng_gy_d = head[3:0];
    end
    if (pop && !head_legal) err_range_d = 1'b1;
    if (state_q == LAUNCH)   wd_d = '0;
    else if (state_q == RUN) wd_d = wd_inc;
  end

  always_comb begin
    eng_start  = (state_q == LAUNCH);
    vga_plot   = eng_pix_valid && (state_q == RUN);
    busy       = (state_q != IDLE) || (count_q != 3'd0);
    req_ready  = (count_q != 3'd4);
    fifo_count = count_q;
  end

  assign eng_op      = eng_op_q;
  assign eng_gx      = eng_gx_q;
  assign eng_gy      = eng_gy_q;
  assign err_range   = err_range_q;
  assign err_timeout = err_timeout_q;
  assign vga_x       = eng_x;
  assign vga_y       = eng_y;
  assign vga_colour  = eng_colour;

endmodule

// File: tb/tb_square_op_scheduler.sv
// Bench for square_op_scheduler: directed scenarios plus randomized request streams
// checked against an in-order list of legal requests.
module tb_square_op_scheduler;

  typedef struct packed {
    logic       op;
    logic [3:0] gx;
    logic [3:0] gy;
  } job_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0, req_op = 1'b0;
  logic [3:0] req_gx = '0, req_gy = '0;
  logic       eng_done = 1'b0, eng_pix_valid = 1'b0;
  logic [7:0] eng_x = '0;
  logic [6:0] eng_y = '0;
  logic [8:0] eng_colour = '0;

  logic       req_ready, eng_start, eng_op, vga_plot, busy, err_range, err_timeout;
  logic [3:0] eng_gx, eng_gy;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [8:0] vga_colour;
  logic [2:0] fifo_count;

  logic       t_req_ready, t_eng_start, t_eng_op, t_vga_plot, t_busy, t_err_range, t_err_timeout;
  logic [3:0] t_eng_gx, t_eng_gy;
  logic [7:0] t_vga_x;
  logic [6:0] t_vga_y;
  logic [8:0] t_vga_colour;
  logic [2:0] t_fifo_count;

  int checks = 0, failures = 0, cyc = 0;
  job_t starts[$];
  int   start_cyc[$];
  int   done_edge[$];
  job_t reqs[$];

  always #5 clk = ~clk;

  square_op_scheduler dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_gx(req_gx), .req_gy(req_gy), .eng_start(eng_start),
    .eng_op(eng_op), .eng_gx(eng_gx), .eng_gy(eng_gy), .eng_done(eng_done),
    .eng_pix_valid(eng_pix_valid), .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour),
    .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .busy(busy), .fifo_count(fifo_count), .err_range(err_range), .err_timeout(err_timeout)
  );

  square_op_scheduler #(.TIMEOUT(16)) dut_to (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(t_req_ready),
    .req_op(req_op), .req_gx(req_gx), .req_gy(req_gy), .eng_start(t_eng_start),
    .eng_op(t_eng_op), .eng_gx(t_eng_gx), .eng_gy(t_eng_gy), .eng_done(eng_done),
    .eng_pix_valid(eng_pix_valid), .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour),
    .vga_plot(t_vga_plot), .vga_x(t_vga_x), .vga_y(t_vga_y), .vga_colour(t_vga_colour),
    .busy(t_busy), .fifo_count(t_fifo_count), .err_range(t_err_range), .err_timeout(t_err_timeout)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (eng_start) begin
      starts.push_back(job_t'({eng_op, eng_gx, eng_gy}));
      start_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0; eng_done = 1'b0; eng_pix_valid = 1'b0;
    resetn = 1'b0;
    step(); step();
    resetn = 1'b1;
    starts.delete(); start_cyc.delete(); done_edge.delete();
  endtask

  task automatic push_all(input bit gaps);
    for (int i = 0; i < reqs.size(); i++) begin
      int guard = 0;
      req_valid = 1'b1;
      {req_op, req_gx, req_gy} = reqs[i];
      while (!req_ready && guard < 3000) begin step(); guard++; end
      step();
      req_valid = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) step();
    end
  endtask

  task automatic serve(input int n, input int maxlat, output int served);
    served = 0;
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      while (!eng_start && guard < 5000) begin step(); guard++; end
      if (!eng_start) break;
      step();
      repeat ($urandom_range(0, maxlat)) step();
      eng_done = 1'b1;
      done_edge.push_back(cyc + 1);
      step();
      eng_done = 1'b0;
      served++;
    end
  endtask

  function automatic job_t rand_job(input int gxmax, input int gymax);
    job_t j;
    j.op = 1'($urandom_range(0, 1));
    j.gx = 4'($urandom_range(0, gxmax));
    j.gy = 4'($urandom_range(0, gymax));
    return j;
  endfunction

  task automatic test_reset();
    do_reset();
    eng_pix_valid = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
    checks++; if (eng_start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b exp 0", eng_start); end
    checks++; if ({eng_op, eng_gx, eng_gy} !== 9'd0) begin failures++; $display("FAIL reset_job: got %0h exp 0", {eng_op, eng_gx, eng_gy}); end
    checks++; if ({err_range, err_timeout} !== 2'b00) begin failures++; $display("FAIL reset_err: got %b exp 00", {err_range, err_timeout}); end
    checks++; if (vga_plot !== 1'b0) begin failures++; $display("FAIL reset_plot: got %b exp 0", vga_plot); end
    eng_pix_valid = 1'b0;
  endtask

  task automatic test_single();
    int n;
    do_reset();
    req_valid = 1'b1; {req_op, req_gx, req_gy} = {1'b0, 4'd3, 4'd2};
    step();
    n = cyc;
    req_valid = 1'b0;
    checks++; if (eng_start !== 1'b0 || fifo_count !== 3'd1) begin failures++; $display("FAIL single_queued: got start=%b count=%0d exp start=0 count=1", eng_start, fifo_count); end
    step();
    checks++; if (eng_start !== 1'b1 || fifo_count !== 3'd0) begin failures++; $display("FAIL single_launch: got start=%b count=%0d exp start=1 count=0", eng_start, fifo_count); end
    checks++; if ({eng_op, eng_gx, eng_gy} !== {1'b0, 4'd3, 4'd2}) begin failures++; $display("FAIL single_coords: got %0h exp 032", {eng_op, eng_gx, eng_gy}); end
    step();
    checks++; if (eng_start !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_run: got start=%b busy=%b exp start=0 busy=1", eng_start, busy); end
    repeat (1197) step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_gap_busy: got %b exp 1", busy); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy: got %b exp 0", busy); end
    checks++; if (start_cyc.size() != 1 || start_cyc[0] != n + 1) begin failures++; $display("FAIL single_latency: got starts=%0d exp 1 at edge %0d", start_cyc.size(), n + 1); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL single_timeout: got %b exp 0", err_timeout); end
  endtask

  task automatic test_back_to_back();
    int served;
    do_reset();
    reqs.delete();
    for (int i = 0; i < 3; i++) reqs.push_back(rand_job(7, 5));
    fork
      push_all(1'b0);
      serve(3, 2, served);
    join
    checks++; if (served != 3 || starts.size() != 3) begin failures++; $display("FAIL b2b_count: got served=%0d starts=%0d exp 3", served, starts.size()); end
    for (int k = 0; k < 3 && k < starts.size(); k++) begin
      checks++; if (starts[k] !== reqs[k]) begin failures++; $display("FAIL b2b_job%0d: got %0h exp %0h", k, starts[k], reqs[k]); end
    end
    for (int k = 0; k < 2 && k + 1 < start_cyc.size() && k < done_edge.size(); k++) begin
      checks++; if (start_cyc[k+1] - done_edge[k] != 2) begin failures++; $display("FAIL b2b_spacing%0d: got %0d exp 2", k, start_cyc[k+1] - done_edge[k]); end
    end
  endtask

  task automatic test_fifo_full();
    int served;
    job_t exp[$];
    do_reset();
    exp.push_back(job_t'({1'b1, 4'd1, 4'd1}));
    req_valid = 1'b1; {req_op, req_gx, req_gy} = exp[0];
    step(); req_valid = 1'b0;
    step(); step();
    for (int i = 0; i < 4; i++) begin
      exp.push_back(rand_job(7, 5));
      req_valid = 1'b1; {req_op, req_gx, req_gy} = exp[i+1];
      step();
    end
    checks++; if (fifo_count !== 3'd4 || req_ready !== 1'b0) begin failures++; $display("FAIL full_state: got count=%0d ready=%b exp count=4 ready=0", fifo_count, req_ready); end
    exp.push_back(rand_job(7, 5));
    {req_op, req_gx, req_gy} = exp[5];
    step(); step(); step();
    checks++; if (fifo_count !== 3'd4 || starts.size() != 1) begin failures++; $display("FAIL full_hold: got count=%0d starts=%0d exp count=4 starts=1", fifo_count, starts.size()); end
    fork
      begin
        int guard = 0;
        while (!req_ready && guard < 100) begin step(); guard++; end
        step();
        req_valid = 1'b0;
      end
      begin
        eng_done = 1'b1; step(); eng_done = 1'b0;
        serve(5, 3, served);
      end
    join
    checks++; if (served != 5 || starts.size() != 6) begin failures++; $display("FAIL full_count: got served=%0d starts=%0d exp 5/6", served, starts.size()); end
    for (int k = 0; k < 6 && k < starts.size(); k++) begin
      checks++; if (starts[k] !== exp[k]) begin failures++; $display("FAIL full_job%0d: got %0h exp %0h", k, starts[k], exp[k]); end
    end
  endtask

  task automatic test_range();
    int served;
    do_reset();
    reqs.delete();
    reqs.push_back(job_t'({1'b1, 4'd2, 4'd4}));
    reqs.push_back(job_t'({1'b0, 4'd8, 4'd1}));
    reqs.push_back(job_t'({1'b1, 4'd2, 4'd6}));
    reqs.push_back(job_t'({1'b0, 4'd7, 4'd5}));
    fork
      push_all(1'b1);
      serve(2, 4, served);
    join
    step(); step();
    checks++; if (served != 2 || starts.size() != 2) begin failures++; $display("FAIL range_count: got served=%0d starts=%0d exp 2", served, starts.size()); end
    checks++; if (starts.size() == 2 && (starts[0] !== reqs[0] || starts[1] !== reqs[3])) begin failures++; $display("FAIL range_jobs: got %0h,%0h exp %0h,%0h", starts[0], starts[1], reqs[0], reqs[3]); end
    checks++; if (err_range !== 1'b1 || err_timeout !== 1'b0) begin failures++; $display("FAIL range_err: got range=%b timeout=%b exp 1/0", err_range, err_timeout); end
  endtask

  task automatic test_pixel_gate();
    logic pv;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [8:0] ec;
    do_reset();
    eng_pix_valid = 1'b1; eng_x = 8'd17; eng_y = 7'd33; eng_colour = 9'h1a5;
    #1;
    checks++; if (vga_plot !== 1'b0) begin failures++; $display("FAIL pix_idle: got %b exp 0", vga_plot); end
    req_valid = 1'b1; {req_op, req_gx, req_gy} = {1'b1, 4'd5, 4'd1};
    step(); req_valid = 1'b0;
    step();
    checks++; if (vga_plot !== 1'b0) begin failures++; $display("FAIL pix_launch: got %b exp 0", vga_plot); end
    step();
    for (int i = 0; i < 6; i++) begin
      pv = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ex = 8'($urandom_range(0, 159)); ey = 7'($urandom_range(0, 119)); ec = 9'($urandom);
      eng_pix_valid = pv; eng_x = ex; eng_y = ey; eng_colour = ec;
      #1;
      checks++; if (vga_plot !== pv || vga_x !== ex || vga_y !== ey || vga_colour !== ec) begin
        failures++; $display("FAIL pix_run%0d: got %b/%0d/%0d/%0h exp %b/%0d/%0d/%0h", i, vga_plot, vga_x, vga_y, vga_colour, pv, ex, ey, ec);
      end
      step();
    end
    eng_pix_valid = 1'b1; eng_done = 1'b1;
    step(); eng_done = 1'b0;
    checks++; if (vga_plot !== 1'b0) begin failures++; $display("FAIL pix_gap: got %b exp 0", vga_plot); end
    eng_pix_valid = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    req_valid = 1'b1; {req_op, req_gx, req_gy} = {1'b1, 4'd4, 4'd3};
    step();
    {req_op, req_gx, req_gy} = {1'b0, 4'd5, 4'd5};
    step(); req_valid = 1'b0;
    checks++; if (t_eng_start !== 1'b1) begin failures++; $display("FAIL to_first_start: got %b exp 1", t_eng_start); end
    repeat (16) step();
    checks++; if (t_err_timeout !== 1'b0) begin failures++; $display("FAIL to_early: got %b exp 0", t_err_timeout); end
    step();
    checks++; if (t_err_timeout !== 1'b1 || t_busy !== 1'b1) begin failures++; $display("FAIL to_abort: got err=%b busy=%b exp 1/1", t_err_timeout, t_busy); end
    step(); step();
    checks++; if (t_eng_start !== 1'b1 || {t_eng_op, t_eng_gx, t_eng_gy} !== {1'b0, 4'd5, 4'd5}) begin
      failures++; $display("FAIL to_next_job: got start=%b job=%0h exp 1/055", t_eng_start, {t_eng_op, t_eng_gx, t_eng_gy});
    end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_long_wd: got %b exp 0", err_timeout); end
  endtask

  task automatic test_reset_midjob();
    int n0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; {req_op, req_gx, req_gy} = {1'b1, 4'(i + 3), 4'(i + 1)};
      step();
    end
    req_valid = 1'b0;
    checks++; if (fifo_count !== 3'd3 || busy !== 1'b1) begin failures++; $display("FAIL mid_queued: got count=%0d busy=%b exp 3/1", fifo_count, busy); end
    resetn = 1'b0; step(); resetn = 1'b1;
    checks++; if (fifo_count !== 3'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL mid_reset: got count=%0d busy=%b ready=%b exp 0/0/1", fifo_count, busy, req_ready); end
    checks++; if (eng_start !== 1'b0 || eng_gx !== 4'd0 || eng_gy !== 4'd0) begin failures++; $display("FAIL mid_job_clr: got start=%b gx=%0d gy=%0d exp 0/0/0", eng_start, eng_gx, eng_gy); end
    n0 = starts.size();
    eng_done = 1'b1; step(); eng_done = 1'b0;
    repeat (8) step();
    checks++; if (starts.size() != n0 || busy !== 1'b0) begin failures++; $display("FAIL mid_stray: got starts=%0d busy=%b exp %0d/0", starts.size(), busy, n0); end
  endtask

  task automatic test_random();
    int served, nlegal;
    bit exp_err;
    job_t exp[$];
    for (int it = 0; it < 3; it++) begin
      do_reset();
      reqs.delete(); exp.delete(); exp_err = 0;
      for (int i = 0; i < 20; i++) begin
        job_t j = rand_job(9, 7);
        reqs.push_back(j);
        if (j.gx < 8 && j.gy < 6) exp.push_back(j);
        else exp_err = 1;
      end
      nlegal = exp.size();
      fork
        push_all(1'b1);
        serve(nlegal, 8, served);
      join
      repeat (5) step();
      checks++; if (served != nlegal || starts.size() != nlegal) begin failures++; $display("FAIL rand%0d_count: got served=%0d starts=%0d exp %0d", it, served, starts.size(), nlegal); end
      for (int k = 0; k < nlegal && k < starts.size(); k++) begin
        checks++; if (starts[k] !== exp[k]) begin failures++; $display("FAIL rand%0d_job%0d: got %0h exp %0h", it, k, starts[k], exp[k]); end
      end
      checks++; if (err_range !== exp_err) begin failures++; $display("FAIL rand%0d_err: got %b exp %b", it, err_range, exp_err); end
      checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL rand%0d_drain: got busy=%b count=%0d exp 0/0", it, busy, fifo_count); end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_range();
    test_pixel_gate();
    test_timeout();
    test_reset_midjob();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
